// File: rtl/led_frame_scheduler_pkg.sv
// led_pkg: shared state encoding, SPRAM geometry and default timing for the
// LED frame scheduler.
package led_pkg;

    localparam int SPRAM_AW         = 14;
    localparam int SPRAM_DW         = 16;
    localparam int DEF_NUM_LEDS     = 144;
    localparam int DEF_LATCH_CYCLES = 14400;   // 300 us at 48 MHz

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_LO     = 3'd1,
        RD_HI     = 3'd2,
        CAPTURE   = 3'd3,
        LOAD      = 3'd4,
        WAIT_DONE = 3'd5,
        LATCH     = 3'd6
    } frame_state_t;

    // Word address of one half of a pixel: low half at 2i, high half at 2i+1.
    function automatic logic [SPRAM_AW-1:0] pixel_addr(
        input logic [SPRAM_AW-2:0] idx,
        input logic                hi_word
    );
        pixel_addr = {idx, hi_word};
    endfunction

endpackage

// File: rtl/led_frame_scheduler.sv
// led_frame_scheduler: walks the frame buffer held in an external SPRAM,
// hands one 24-bit pixel at a time to an external LED driver, then holds the
// latch gap. Host writes share the SPRAM port whenever the reader is not
// using it.
module led_frame_scheduler #(
    parameter int NUM_LEDS     = led_pkg::DEF_NUM_LEDS,
    parameter int LATCH_CYCLES = led_pkg::DEF_LATCH_CYCLES
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         wr_req,
    input  logic [led_pkg::SPRAM_AW-1:0] wr_addr,
    input  logic [led_pkg::SPRAM_DW-1:0] wr_data,
    output logic                         wr_ack,
    output logic [led_pkg::SPRAM_AW-1:0] spram_addr,
    output logic [led_pkg::SPRAM_DW-1:0] spram_din,
    output logic                         spram_we,
    input  logic [led_pkg::SPRAM_DW-1:0] spram_dout,
    output logic [23:0]                  rgb,
    output logic                         load,
    input  logic                         done,
    output logic                         latch,
    output logic                         frame_done,
    output logic                         busy
);
    import led_pkg::*;

    localparam int PIX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int LAT_W = $clog2(LATCH_CYCLES + 1);
    localparam int IDX_W = SPRAM_AW - 1;

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_LEDS - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);

    frame_state_t            state_r;
    frame_state_t            state_s;
    logic [PIX_W-1:0]        pix_r;
    logic [LAT_W-1:0]        lat_cnt_r;
    logic [SPRAM_DW-1:0]     lo_word_r;
    logic [23:0]             rgb_r;
    logic                    load_r;
    logic                    latch_r;
    logic                    frame_done_r;
    logic                    busy_r;

    logic                    last_pix_s;
    logic                    lat_end_s;
    logic                    reader_owns_s;
    logic                    wr_ack_s;
    logic [SPRAM_AW-1:0]     spram_addr_s;
    logic [SPRAM_DW-1:0]     spram_din_s;

    assign last_pix_s = (pix_r == PIX_LAST);
    assign lat_end_s  = (lat_cnt_r == LAT_LAST);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; enable is only sampled in IDLE and at the end of the
    // latch gap, so dropping it mid-frame lets the frame finish.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_s = RD_LO;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_LO:   state_s = RD_HI;
            RD_HI:   state_s = CAPTURE;
            CAPTURE: state_s = LOAD;
            LOAD:    state_s = WAIT_DONE;
            WAIT_DONE: begin
                if (!done) begin
                    state_s = WAIT_DONE;
                end else if (last_pix_s) begin
                    state_s = LATCH;
                end else begin
                    state_s = RD_LO;
                end
            end
            LATCH: begin
                if (!lat_end_s) begin
                    state_s = LATCH;
                end else if (enable) begin
                    state_s = RD_LO;
                end else begin
                    state_s = IDLE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Pixel index: advances on the driver's done, returns to 0 between frames,
    // never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_r <= {PIX_W{1'b0}};
        end else if ((state_r == WAIT_DONE) && done && !last_pix_s) begin
            pix_r <= pix_r + PIX_W'(1'b1);
        end else if ((state_r == IDLE) || (state_r == LATCH)) begin
            pix_r <= {PIX_W{1'b0}};
        end else begin
            pix_r <= pix_r;
        end
    end

    // Latch gap counter: counts 0..LATCH_CYCLES-1 while in LATCH, else parked at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_cnt_r <= {LAT_W{1'b0}};
        end else if ((state_r == LATCH) && !lat_end_s) begin
            lat_cnt_r <= lat_cnt_r + LAT_W'(1'b1);
        end else begin
            lat_cnt_r <= {LAT_W{1'b0}};
        end
    end

    // Pixel assembly: the low word is staged so rgb only changes as LOAD is
    // entered and stays put between loads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lo_word_r <= {SPRAM_DW{1'b0}};
            rgb_r     <= 24'h00_0000;
        end else if (state_r == RD_HI) begin
            lo_word_r <= spram_dout;
            rgb_r     <= rgb_r;
        end else if (state_r == CAPTURE) begin
            lo_word_r <= lo_word_r;
            rgb_r     <= {spram_dout[7:0], lo_word_r};
        end else begin
            lo_word_r <= lo_word_r;
            rgb_r     <= rgb_r;
        end
    end

    // Registered status strobes decoded from the upcoming state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_r       <= 1'b0;
            latch_r      <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            load_r       <= (state_s == LOAD);
            latch_r      <= (state_s == LATCH);
            frame_done_r <= (state_r == LATCH) && lat_end_s;
            busy_r       <= (state_s != IDLE);
        end
    end

    // SPRAM port mux: the reader owns it in RD_LO/RD_HI, otherwise a pending
    // host write goes straight through; nothing is committed during reset.
    always_comb begin
        reader_owns_s = (state_r == RD_LO) || (state_r == RD_HI);
        wr_ack_s      = wr_req && !reader_owns_s && !reset;
        spram_addr_s  = {SPRAM_AW{1'b0}};
        spram_din_s   = {SPRAM_DW{1'b0}};
        if (state_r == RD_LO) begin
            spram_addr_s = pixel_addr(IDX_W'(pix_r), 1'b0);
        end else if (state_r == RD_HI) begin
            spram_addr_s = pixel_addr(IDX_W'(pix_r), 1'b1);
        end else if (wr_ack_s) begin
            spram_addr_s = wr_addr;
            spram_din_s  = wr_data;
        end else begin
            spram_addr_s = {SPRAM_AW{1'b0}};
            spram_din_s  = {SPRAM_DW{1'b0}};
        end
    end

    assign wr_ack     = wr_ack_s;
    assign spram_we   = wr_ack_s;
    assign spram_addr = spram_addr_s;
    assign spram_din  = spram_din_s;
    assign rgb        = rgb_r;
    assign load       = load_r;
    assign latch      = latch_r;
    assign frame_done = frame_done_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Self-checking bench for led_frame_scheduler with a 1-cycle SPRAM model and
// an LED driver model that answers done 20 cycles after each load.
module tb_led_frame_scheduler;

    localparam int NL = 4;
    localparam int LC = 10;

    logic        clk = 1'b0;
    logic        reset, enable, wr_req, wr_ack, spram_we, load, done, latch, frame_done, busy;
    logic [13:0] wr_addr, spram_addr;
    logic [15:0] wr_data, spram_din, spram_dout;
    logic [23:0] rgb;
    logic        done_force;
    int          drv_cnt;

    logic [15:0] mem [0:16383];
    logic [15:0] shadow [0:15];
    logic [23:0] exp_q [$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          frame_loads, done_frame_loads, frame_dones, lat_run;
    logic        busy_q, load_q;
    logic [23:0] last_rgb;

    typedef struct {
        logic        req;
        logic [13:0] addr;
        logic [15:0] data;
        logic        exp_ack;
        logic [13:0] exp_addr;
        logic [15:0] exp_din;
    } wr_vec_t;

    wr_vec_t vecs [12];

    always #5 clk = ~clk;

    led_frame_scheduler #(.NUM_LEDS(NL), .LATCH_CYCLES(LC)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .spram_addr(spram_addr), .spram_din(spram_din), .spram_we(spram_we),
        .spram_dout(spram_dout), .rgb(rgb), .load(load), .done(done),
        .latch(latch), .frame_done(frame_done), .busy(busy)
    );

    // SPRAM model: read-before-write, one cycle read latency.
    always @(posedge clk) begin
        if (spram_we) mem[spram_addr] <= spram_din;
        spram_dout <= mem[spram_addr];
    end

    // LED driver model: done pulse roughly 20 cycles after each load.
    always @(negedge clk) begin
        if (reset)              drv_cnt <= 0;
        else if (load)          drv_cnt <= 20;
        else if (drv_cnt != 0)  drv_cnt <= drv_cnt - 1;
    end
    assign done = (drv_cnt == 1) || done_force;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic push_frame();
        for (int k = 0; k < NL; k++) exp_q.push_back({shadow[2*k+1][7:0], shadow[2*k]});
    endtask

    // Monitor / scoreboard: frame expectations queued at frame start, popped on load.
    initial begin
        busy_q = 1'b0; load_q = 1'b0; lat_run = 0; frame_loads = 0;
        done_frame_loads = 0; frame_dones = 0; last_rgb = 24'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                busy_q = 1'b0; load_q = 1'b0; lat_run = 0; frame_loads = 0; last_rgb = 24'h0;
            end else begin
                if (frame_done) begin
                    done_frame_loads = frame_loads;
                    frame_dones++;
                end
                if ((busy && !busy_q) || (frame_done && busy)) begin
                    frame_loads = 0;
                    push_frame();
                end
                if (load) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_load: got rgb %h expected no load at %0t", rgb, $time);
                    end else begin
                        check("load_rgb", {8'h0, rgb}, {8'h0, exp_q.pop_front()});
                    end
                    check("load_one_cycle", {31'h0, load_q}, 32'h0);
                    frame_loads++;
                    last_rgb = rgb;
                end else begin
                    check("rgb_hold", {8'h0, rgb}, {8'h0, last_rgb});
                end
                if (latch) begin
                    lat_run++;
                end else if (lat_run != 0) begin
                    check("latch_len", lat_run, LC);
                    check("frame_done_at_latch_end", {31'h0, frame_done}, 32'h1);
                    lat_run = 0;
                end else begin
                    check("frame_done_outside_latch_end", {31'h0, frame_done}, 32'h0);
                end
                busy_q = busy;
                load_q = load;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_frame_done(input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            step();
            if (frame_done) begin ok = 1'b1; break; end
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL %s: got timeout expected frame_done", name); end
    endtask

    task automatic wait_loads(input int n, input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            step();
            if (frame_loads >= n) begin ok = 1'b1; break; end
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL %s: got timeout expected %0d loads", name, n); end
    endtask

    task automatic wait_latch(input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            step();
            if (latch) begin ok = 1'b1; break; end
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL %s: got timeout expected latch", name); end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"},  {31'h0, busy}, 32'h0);
        check({name, "_load"},  {31'h0, load}, 32'h0);
        check({name, "_latch"}, {31'h0, latch}, 32'h0);
        check({name, "_fdone"}, {31'h0, frame_done}, 32'h0);
        check({name, "_rgb"},   {8'h0, rgb}, 32'h0);
        check({name, "_addr"},  {18'h0, spram_addr}, 32'h0);
        check({name, "_ack"},   {31'h0, wr_ack}, 32'h0);
        check({name, "_we"},    {31'h0, spram_we}, 32'h0);
        check({name, "_din"},   {16'h0, spram_din}, 32'h0);
    endtask

    int fd_before;

    initial begin
        reset = 1'b1; enable = 1'b0; wr_req = 1'b0; wr_addr = 14'h0; wr_data = 16'h0;
        done_force = 1'b0;
        for (int k = 0; k < 16; k++) shadow[k] = 16'h0;

        // write-port vector table: preload 0xCEFF/0x0000 pairs plus idle rows
        for (int k = 0; k < 8; k++) begin
            vecs[k] = '{1'b1, 14'(k), ((k % 2) == 0) ? 16'hCEFF : 16'h0000,
                        1'b1, 14'(k), ((k % 2) == 0) ? 16'hCEFF : 16'h0000};
        end
        vecs[8]  = '{1'b0, 14'h0155, 16'hBEEF, 1'b0, 14'h0000, 16'h0000};
        vecs[9]  = '{1'b1, 14'h3FFF, 16'hA5A5, 1'b1, 14'h3FFF, 16'hA5A5};
        vecs[10] = '{1'b0, 14'h2AAA, 16'h5A5A, 1'b0, 14'h0000, 16'h0000};
        vecs[11] = '{1'b1, 14'h000A, 16'h7777, 1'b1, 14'h000A, 16'h7777};

        // reset state
        repeat (3) step();
        check_all_zero("reset");
        reset = 1'b0;
        step();
        check("idle_busy", {31'h0, busy}, 32'h0);

        // table-driven writes in IDLE
        for (int r = 0; r < 12; r++) begin
            step();
            wr_req = vecs[r].req; wr_addr = vecs[r].addr; wr_data = vecs[r].data;
            #1;
            check("tbl_ack",  {31'h0, wr_ack},    {31'h0, vecs[r].exp_ack});
            check("tbl_we",   {31'h0, spram_we},  {31'h0, vecs[r].exp_ack});
            check("tbl_addr", {18'h0, spram_addr}, {18'h0, vecs[r].exp_addr});
            check("tbl_din",  {16'h0, spram_din}, {16'h0, vecs[r].exp_din});
            if (vecs[r].exp_ack && vecs[r].addr < 14'd16) shadow[vecs[r].addr[3:0]] = vecs[r].data;
        end
        step();
        wr_req = 1'b0;

        // write and enable in the same IDLE cycle
        step();
        enable = 1'b1; wr_req = 1'b1; wr_addr = 14'h0008; wr_data = 16'hABCD;
        #1;
        check("same_cycle_ack", {31'h0, wr_ack}, 32'h1);
        check("same_cycle_addr", {18'h0, spram_addr}, 32'h8);
        check("same_cycle_busy", {31'h0, busy}, 32'h0);
        shadow[8] = 16'hABCD;
        step();
        wr_req = 1'b0;
        #1;
        check("rd_lo_after_idle_busy", {31'h0, busy}, 32'h1);
        check("rd_lo_after_idle_addr", {18'h0, spram_addr}, 32'h0);

        // first frame: four loads of 0x00CEFF, latch, frame_done, refetch pixel 0
        wait_frame_done("frame1_done");
        check("frame1_loads", done_frame_loads, NL);
        check("frame1_count", frame_dones, 1);
        check("frame1_last_rgb", {8'h0, last_rgb}, 32'h0000CEFF);
        check("refetch_busy", {31'h0, busy}, 32'h1);
        check("refetch_addr", {18'h0, spram_addr}, 32'h0);

        // write held from RD_LO: stalled through RD_HI, committed in CAPTURE
        wr_req = 1'b1; wr_addr = 14'h0002; wr_data = 16'h1234;
        #1;
        check("stall_rdlo_ack", {31'h0, wr_ack}, 32'h0);
        check("stall_rdlo_addr", {18'h0, spram_addr}, 32'h0);
        step();
        check("stall_rdhi_ack", {31'h0, wr_ack}, 32'h0);
        check("stall_rdhi_addr", {18'h0, spram_addr}, 32'h1);
        step();
        check("capture_ack", {31'h0, wr_ack}, 32'h1);
        check("capture_we", {31'h0, spram_we}, 32'h1);
        check("capture_addr", {18'h0, spram_addr}, 32'h2);
        check("capture_din", {16'h0, spram_din}, 32'h1234);
        shadow[2] = 16'h1234;
        exp_q.delete();
        push_frame();
        step();
        wr_req = 1'b0;

        wait_frame_done("frame2_done");
        check("frame2_count", frame_dones, 2);
        wait_loads(2, "frame3_pix1");
        check("next_frame_pix1", {8'h0, last_rgb}, 32'h00001234);

        // drop enable during pixel 2: frame still completes
        wait_loads(3, "frame3_pix2");
        enable = 1'b0;
        wait_frame_done("frame3_done");
        check("drop_loads", done_frame_loads, NL);
        check("drop_busy", {31'h0, busy}, 32'h0);
        repeat (3) step();
        check("drop_stays_idle", {31'h0, busy}, 32'h0);
        check("drop_frame_count", frame_dones, 3);

        // done pulse in IDLE is ignored
        done_force = 1'b1;
        step();
        done_force = 1'b0;
        repeat (3) step();
        check("idle_done_busy", {31'h0, busy}, 32'h0);
        check("idle_done_queue", exp_q.size(), 0);

        // done pulse in LATCH is ignored
        enable = 1'b1;
        wait_latch("latch_reached");
        enable = 1'b0;
        done_force = 1'b1;
        step();
        done_force = 1'b0;
        wait_frame_done("frame4_done");
        check("latch_done_loads", done_frame_loads, NL);
        check("latch_done_busy", {31'h0, busy}, 32'h0);
        check("latch_done_count", frame_dones, 4);

        // reset in WAIT_DONE of pixel 1
        enable = 1'b1;
        wait_loads(2, "reset_pix1");
        step();
        fd_before = frame_dones;
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        repeat (3) step();
        check("held_reset_fdone", {31'h0, frame_done}, 32'h0);
        reset = 1'b0;
        step();
        check("restart_busy", {31'h0, busy}, 32'h1);
        check("restart_addr", {18'h0, spram_addr}, 32'h0);
        enable = 1'b0;
        wait_frame_done("frame5_done");
        check("restart_fdone_count", frame_dones, fd_before + 1);
        check("restart_loads", done_frame_loads, NL);

        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_frame_scheduler.md
LED_FRAME_SCHEDULER -- requirements
Module: led_frame_scheduler

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 144, the number of pixels per frame; legal range 1..8192.
REQ-002 SHALL have parameter LATCH_CYCLES, default 14400, the length of the post-frame latch gap in clk cycles (300 us at 48 MHz).
REQ-003 SHALL have port clk, input, 1, the single clock (48 MHz HSOSC domain).
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port enable, input, 1, which requests continuous frame refresh while high.
REQ-006 SHALL have port wr_req, input, 1, a host write request.
REQ-007 SHALL have port wr_addr, input, 14, the host write word address.
REQ-008 SHALL have port wr_data, input, 16, the host write data.
REQ-009 SHALL have port wr_ack, output, 1, asserted in the cycle a host write is committed.
REQ-010 SHALL have port spram_addr, output, 14, the SPRAM address.
REQ-011 SHALL have port spram_din, output, 16, the SPRAM write data.
REQ-012 SHALL have port spram_we, output, 1, the SPRAM write enable.
REQ-013 SHALL have port spram_dout, input, 16, the SPRAM read data.
REQ-014 SHALL have port rgb, output, 24, the pixel presented to the LED driver.
REQ-015 SHALL have port load, output, 1, a one-cycle strobe telling the driver rgb is valid.
REQ-016 SHALL have port done, input, 1, the driver's pulse indicating the pixel has been shifted out.
REQ-017 SHALL have port latch, output, 1, held high during the latch gap.
REQ-018 SHALL have port frame_done, output, 1, a one-cycle pulse at the end of each latch gap.
REQ-019 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-020 Pixel i SHALL be stored with rgb[15:0] at word 2i and rgb[23:16] in bits [7:0] of word 2i+1.
REQ-021 SPRAM read latency SHALL be one cycle: spram_dout is valid in the cycle after spram_addr is presented.
REQ-022 The FSM SHALL have the states IDLE, RD_LO, RD_HI, CAPTURE, LOAD, WAIT_DONE and LATCH.
REQ-023 IDLE SHALL go to RD_LO with the pixel index set to 0 when enable=1; otherwise it SHALL stay in IDLE.
REQ-024 In RD_LO the block SHALL drive spram_addr=2i and go to RD_HI.
REQ-025 In RD_HI the block SHALL drive spram_addr=2i+1, capture spram_dout into rgb[15:0], and go to CAPTURE.
REQ-026 In CAPTURE the block SHALL capture spram_dout[7:0] into rgb[23:16] and go to LOAD.
REQ-027 In LOAD the block SHALL assert load for exactly one cycle, hold rgb stable, and go to WAIT_DONE.
REQ-028 WAIT_DONE SHALL hold until done=1; it SHALL then go to LATCH if i==NUM_LEDS-1, else increment i and go to RD_LO.
REQ-029 LATCH SHALL assert latch for exactly LATCH_CYCLES cycles.
REQ-030 At the end of LATCH the block SHALL pulse frame_done for one cycle, then go to RD_LO with i=0 if enable=1, else to IDLE.
REQ-031 Deasserting enable mid-frame SHALL NOT abort the frame; the current frame completes, including LATCH.
REQ-032 rgb SHALL hold its value between loads.
REQ-033 A done pulse arriving outside WAIT_DONE SHALL be ignored.
REQ-034 The SPRAM port SHALL be owned by the reader in RD_LO and RD_HI, and SHALL be free in all other states.
REQ-035 wr_ack SHALL be wr_req AND port-free, combinationally.
REQ-036 spram_we SHALL equal wr_ack; when wr_ack=1, spram_addr=wr_addr and spram_din=wr_data.
REQ-037 A stalled write SHALL remain pending; wr_req, wr_addr and wr_data are held by the host until wr_ack.
REQ-038 Writes SHALL be accepted at up to one per cycle while the port is free, including in the IDLE-to-RD_LO transition cycle.
REQ-039 When no write is in progress, spram_we=0 and spram_din=0.
REQ-040 The pixel counter width SHALL be $clog2(NUM_LEDS), min 1; the latch counter width SHALL be $clog2(LATCH_CYCLES+1); neither counter SHALL wrap.

Reset
REQ-041 Reset SHALL act immediately in any state: state=IDLE, i=0, latch counter=0, rgb=0, load=0, latch=0, frame_done=0, busy=0, spram_addr=0.
REQ-042 On reset the block SHALL drop any in-flight frame with no frame_done; the first frame after release restarts at pixel 0.

Structure
REQ-043 Package led_pkg SHALL hold the state enum, SPRAM_AW=14, SPRAM_DW=16 and the default timing constants.
REQ-044 No sub-module SHALL be instantiated; the SPRAM (SP256K) and the LED driver remain external and are wired in top.

Verification (NUM_LEDS=4, LATCH_CYCLES=10; SPRAM model with 1-cycle latency; driver model returns done 20 cycles after load)
REQ-045 Preload words 0..7 = 0xCEFF,0x0000 repeated, enable=1 -> four load strobes, each with rgb=0x00CEFF, latch high for 10 cycles, one frame_done, then pixel 0 fetched again.
REQ-046 wr_req held with addr=0x0002, data=0x1234 starting in RD_LO -> wr_ack=0 in RD_LO and RD_HI, wr_ack=1 in CAPTURE, and the next frame's pixel 1 has rgb[15:0]=0x1234.
REQ-047 wr_req and enable rising in the same IDLE cycle -> write acked that cycle and RD_LO the next cycle.
REQ-048 enable dropped during pixel 2 -> pixels 2 and 3 are still loaded, LATCH runs, frame_done pulses, then IDLE with busy=0.
REQ-049 reset asserted in WAIT_DONE of pixel 1 -> all outputs 0 in that cycle, no frame_done; after release with enable=1 the first fetch is at spram_addr=0.
REQ-050 done pulsed in IDLE and in LATCH -> no state change and no extra load.
